// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

  localparam int unsigned PERIOD_MIN = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer with history flop; emits a registered one-cycle
// pulse on each synchronized rising edge of an asynchronous input.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_rise;
  logic                   w_sync_out;

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // Pulse is registered: a sample taken at edge k is seen as rise during the
  // cycle after edge k+SYNC_STAGES.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= w_sync_out;
      r_rise <= w_sync_out & ~r_hist;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/period_meter.sv
// Measures the spacing of rising edges on an asynchronous input in system
// clock cycles, reporting each completed period with a one-cycle strobe.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned BITS        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sig_in,
  output logic [BITS-1:0] period,
  output logic            valid,
  output logic            overflow,
  output logic            locked
);

  logic            w_rise;
  meter_state_t    r_state;
  logic [BITS-1:0] r_count;
  logic            r_sat;
  logic [BITS-1:0] r_period;
  logic            r_valid;
  logic            r_overflow;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(sig_in),
    .rise    (w_rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_sat      <= 1'b0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= MEASURE;
            r_count <= BITS'(1);
            r_sat   <= 1'b0;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            r_period   <= r_count;
            r_overflow <= r_sat;
            r_valid    <= 1'b1;
            r_count    <= BITS'(1);
            r_sat      <= 1'b0;
          end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
          end else begin
            // Counter parks at all-ones; the flag marks that time was lost.
            r_sat <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign period   = r_period;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign locked   = (r_state == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: table-driven waveforms with a
// scoreboard of expected reports, plus reset and lock sequences.
module tb_period_meter;

  localparam int S   = 2;
  localparam int LAT = S + 2;  // drive cycle to valid-visible cycle

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sig0  = 1'b0;
  logic        sig1  = 1'b0;
  logic [15:0] per0;
  logic        v0, o0, l0;
  logic [3:0]  per1;
  logic        v1, o1, l1;

  period_meter #(.BITS(16), .SYNC_STAGES(S)) u_dut16 (
    .clock(clock), .reset(reset), .sig_in(sig0),
    .period(per0), .valid(v0), .overflow(o0), .locked(l0)
  );

  period_meter #(.BITS(4), .SYNC_STAGES(S)) u_dut4 (
    .clock(clock), .reset(reset), .sig_in(sig1),
    .period(per1), .valid(v1), .overflow(o1), .locked(l1)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int w;
    int per;
    bit ovf;
    int due;
  } exp_t;

  typedef struct {
    int w;
    int hi;
    int lo;
    int n;
    int exp_per;
    bit exp_ovf;
  } row_t;

  exp_t q[$];
  row_t rows[8];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   armed[2];
  int   last_rise[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_report(input int w, input logic [31:0] per, input logic ovf);
    exp_t e;
    if (q.size() == 0 || q[0].w != w) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_valid: dut %0d reported period %0d at cycle %0d, expected no report",
               w, per, cyc);
    end else begin
      e = q.pop_front();
      check(w == 0 ? "period16" : "period4", per, e.per);
      check(w == 0 ? "overflow16" : "overflow4", {31'b0, ovf}, {31'b0, e.ovf});
      check("report_cycle", cyc, e.due);
    end
  endtask

  always @(negedge clock) begin
    if (v0) mon_report(0, 32'(per0), o0);
    if (v1) mon_report(1, 32'(per1), o1);
    if (q.size() > 0 && cyc > q[0].due) begin
      check("late_report_cycle", cyc, q[0].due);
      void'(q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rise_now(input int w, input bit use_row, input int rp, input bit ro);
    exp_t e;
    int   gap;
    int   mx;
    gap = cyc - last_rise[w];
    mx  = (w == 0) ? 65535 : 15;
    if (w == 0) sig0 = 1'b1;
    else        sig1 = 1'b1;
    if (armed[w]) begin
      e.w   = w;
      e.per = use_row ? rp : ((gap > mx) ? mx : gap);
      e.ovf = use_row ? ro : (gap > mx);
      e.due = cyc + LAT;
      q.push_back(e);
    end
    armed[w]     = 1'b1;
    last_rise[w] = cyc;
  endtask

  task automatic fall_now(input int w);
    if (w == 0) sig0 = 1'b0;
    else        sig1 = 1'b0;
  endtask

  task automatic send_row(input row_t r);
    for (int i = 0; i < r.n; i++) begin
      rise_now(r.w, i > 0, r.exp_per, r.exp_ovf);
      tick(r.hi);
      fall_now(r.w);
      tick(r.lo);
    end
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() > 0 && g < 500) begin
      tick(1);
      g++;
    end
    if (q.size() > 0) begin
      check("pending_reports", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    rows = '{
      '{0, 4, 4, 6,  8, 1'b0},   // steady square wave
      '{0, 1, 1, 8,  2, 1'b0},   // minimum period
      '{0, 3, 3, 5,  6, 1'b0},
      '{0, 6, 6, 4, 12, 1'b0},   // period change 6 -> 12
      '{1, 10, 10, 3, 15, 1'b1}, // saturation
      '{1, 2, 4, 3,  6, 1'b0},   // flag cleared after saturation
      '{1, 7, 8, 3, 15, 1'b0},   // exactly all-ones, not saturated
      '{1, 8, 8, 2, 15, 1'b1}    // one past all-ones
    };
    armed     = '{1'b0, 1'b0};
    last_rise = '{0, 0};

    // Reset held with sig_in toggling
    for (int i = 0; i < 3; i++) begin
      sig0 = ~sig0;
      sig1 = ~sig1;
      tick(1);
      check("rst_period", 32'(per0), 0);
      check("rst_valid", {31'b0, v0}, 0);
      check("rst_overflow", {31'b0, o0}, 0);
      check("rst_locked", {31'b0, l0}, 0);
      check("rst_locked4", {31'b0, l1}, 0);
    end
    reset = 1'b0;
    sig0  = 1'b0;
    sig1  = 1'b0;
    tick(2);

    // Lock timing on first rise after reset
    rise_now(0, 1'b0, 0, 1'b0);
    tick(3);
    check("locked_before", {31'b0, l0}, 0);
    tick(1);
    check("locked_after", {31'b0, l0}, 1);
    fall_now(0);
    tick(4);

    for (int r = 0; r < 8; r++) begin
      send_row(rows[r]);
      wait_drain();
    end
    check("locked_held", {31'b0, l0}, 1);

    // Reset mid-measurement on a period-10 wave
    send_row('{0, 5, 5, 3, 10, 1'b0});
    wait_drain();
    tick(5);
    check("pre_reset_period", 32'(per0), 10);
    reset = 1'b1;
    tick(2);
    check("midrst_locked", {31'b0, l0}, 0);
    check("midrst_period", 32'(per0), 0);
    check("midrst_overflow", {31'b0, o0}, 0);
    check("midrst_locked4", {31'b0, l1}, 0);
    reset = 1'b0;
    armed = '{1'b0, 1'b0};
    tick(2);
    send_row('{0, 5, 5, 3, 10, 1'b0});
    wait_drain();
    tick(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
